// File: rtl/fft_pkg.sv
// Shared constants for the FFT datapath.
// Defaults used by the output reorder stage and the input scramble stage.
package fft_pkg;
    localparam int FFT_SAMPLES = 4;
    localparam int FFT_WIDTH   = 2;
endpackage

// File: rtl/bit_reverse_index.sv
// Combinational bit-order reversal of an index.
// Shared by the input scramble and output reorder stages.
module bit_reverse_index #(
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx_in,
    output logic [IDX_W-1:0] idx_out
);
    always_comb begin
        idx_out = '0;
        for (int i = 0; i < IDX_W; i++) begin
            idx_out[i] = idx_in[IDX_W-1-i];
        end
    end
endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: writes each bit-reversed FFT frame at its natural bin
// address and streams full banks out in natural bin order.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES,
    parameter int WIDTH   = FFT_WIDTH,
    localparam int IDX_W  = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic [1:0]       full_q, full_d;
    logic [IDX_W-1:0] wc_q, wc_d;
    logic [IDX_W-1:0] rc_q, rc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] bank_q [2][SAMPLES];
    logic [WIDTH-1:0] bank_d [2][SAMPLES];

    logic [IDX_W-1:0] wr_addr;
    logic             wr_en;
    logic             load;

    bit_reverse_index #(.IDX_W(IDX_W)) u_wr_addr (
        .idx_in  (wc_q),
        .idx_out (wr_addr)
    );

    assign in_ready = rst_n & ~full_q[wb_q];
    assign wr_en    = in_valid & in_ready;
    assign load     = full_q[rb_q] & (~out_valid_q | out_ready);

    // The write bank is never full and the read bank always is, so the two
    // full-flag updates below can never target the same bank.
    always_comb begin
        wb_d        = wb_q;
        rb_d        = rb_q;
        full_d      = full_q;
        wc_d        = wc_q;
        rc_d        = rc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        bank_d      = bank_q;

        if (wr_en) begin
            bank_d[wb_q][wr_addr] = in_data;
            wc_d = wc_q + IDX_W'(1);
            if (wc_q == LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end

        if (load) begin
            out_data_d  = bank_q[rb_q][rc_q];
            out_index_d = rc_q;
            out_last_d  = (rc_q == LAST_IDX);
            out_valid_d = 1'b1;
            rc_d        = rc_q + IDX_W'(1);
            if (rc_q == LAST_IDX) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= 2'b00;
            wc_q        <= '0;
            rc_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            wc_q        <= wc_d;
            rc_q        <= rc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Sample storage carries no reset; only the flags decide what is readable.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// Bench for fft_output_reorder: table vectors, corner sequences and a
// per-instance natural-order scoreboard for SAMPLES = 4, 8 and 16.
module tb_fft_output_reorder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] idx;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] din[4];
        logic [7:0] dout[4];
    } vec_t;

    // ---------------- instances ----------------
    logic       in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 0, out_last4;
    logic [7:0] in_data4 = 0, out_data4;
    logic [1:0] out_index4;
    logic       in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 1, out_last8;
    logic [7:0] in_data8 = 0, out_data8;
    logic [2:0] out_index8;
    logic       in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0, out_last16;
    logic [7:0] in_data16 = 0, out_data16;
    logic [3:0] out_index16;

    fft_output_reorder #(.SAMPLES(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_index(out_index4), .out_last(out_last4));
    fft_output_reorder #(.SAMPLES(8), .WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_index(out_index8), .out_last(out_last8));
    fft_output_reorder #(.SAMPLES(16), .WIDTH(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_data(in_data16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_data(out_data16), .out_index(out_index16), .out_last(out_last16));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) if (v[i]) r |= 1 << (bits - 1 - i);
        return r;
    endfunction

    // ---------------- scoreboards ----------------
    exp_t q4[$], q8[$], q16[$];
    logic [7:0] fr4[4], fr8[8], fr16[16];
    int k4 = 0, k8 = 0, k16 = 0, rcv16 = 0;
    logic st4 = 0, st8 = 0, st16 = 0;
    logic [7:0] hd4, hd8, hd16;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            q4.delete(); k4 = 0; st4 = 0;
        end else begin
            if (st4) begin
                chk("hold4_valid", 32'(out_valid4), 1);
                chk("hold4_data", 32'(out_data4), 32'(hd4));
            end
            if (in_valid4 && in_ready4) begin
                fr4[brev(k4, 2)] = in_data4;
                k4++;
                if (k4 == 4) begin
                    for (int b = 0; b < 4; b++) q4.push_back('{d: fr4[b], idx: 8'(b), last: (b == 3)});
                    k4 = 0;
                end
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) chk("extra4", 32'(out_data4), 32'hFFFF_FFFF);
                else begin
                    e = q4.pop_front();
                    chk("sb4_data", 32'(out_data4), 32'(e.d));
                    chk("sb4_index", 32'(out_index4), 32'(e.idx));
                    chk("sb4_last", 32'(out_last4), 32'(e.last));
                end
            end
            st4 = out_valid4 && !out_ready4;
            hd4 = out_data4;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            q8.delete(); k8 = 0; st8 = 0;
        end else begin
            if (st8) chk("hold8_data", 32'(out_data8), 32'(hd8));
            if (in_valid8 && in_ready8) begin
                fr8[brev(k8, 3)] = in_data8;
                k8++;
                if (k8 == 8) begin
                    for (int b = 0; b < 8; b++) q8.push_back('{d: fr8[b], idx: 8'(b), last: (b == 7)});
                    k8 = 0;
                end
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) chk("extra8", 32'(out_data8), 32'hFFFF_FFFF);
                else begin
                    e = q8.pop_front();
                    chk("sb8_data", 32'(out_data8), 32'(e.d));
                    chk("sb8_index", 32'(out_index8), 32'(e.idx));
                    chk("sb8_last", 32'(out_last8), 32'(e.last));
                end
            end
            st8 = out_valid8 && !out_ready8;
            hd8 = out_data8;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            q16.delete(); k16 = 0; st16 = 0; rcv16 = 0;
        end else begin
            if (st16) begin
                chk("hold16_valid", 32'(out_valid16), 1);
                chk("hold16_data", 32'(out_data16), 32'(hd16));
            end
            if (in_valid16 && in_ready16) begin
                fr16[brev(k16, 4)] = in_data16;
                k16++;
                if (k16 == 16) begin
                    for (int b = 0; b < 16; b++) q16.push_back('{d: fr16[b], idx: 8'(b), last: (b == 15)});
                    k16 = 0;
                end
            end
            if (out_valid16 && out_ready16) begin
                rcv16++;
                if (q16.size() == 0) chk("extra16", 32'(out_data16), 32'hFFFF_FFFF);
                else begin
                    e = q16.pop_front();
                    chk("sb16_data", 32'(out_data16), 32'(e.d));
                    chk("sb16_index", 32'(out_index16), 32'(e.idx));
                    chk("sb16_last", 32'(out_last16), 32'(e.last));
                end
            end
            st16 = out_valid16 && !out_ready16;
            hd16 = out_data16;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send4(input logic [7:0] d);
        int n = 0;
        in_valid4 = 1'b1;
        in_data4  = d;
        #1;
        while (!in_ready4 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("send4_timeout", 32'(in_ready4), 1);
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    task automatic drain4();
        int n = 0;
        #1;
        while ((q4.size() != 0 || out_valid4) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("drain4_left", 32'(q4.size()), 0);
        @(negedge clk);
    endtask

    vec_t tbl[3];

    initial begin
        tbl[0].din = '{8'd10, 8'd30, 8'd20, 8'd40}; tbl[0].dout = '{8'd10, 8'd20, 8'd30, 8'd40};
        tbl[1].din = '{8'd1, 8'd2, 8'd3, 8'd4};     tbl[1].dout = '{8'd1, 8'd3, 8'd2, 8'd4};
        tbl[2].din = '{8'hAA, 8'h55, 8'hFF, 8'h00}; tbl[2].dout = '{8'hAA, 8'hFF, 8'h55, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid4), 0);
        chk("rst_out_data", 32'(out_data4), 0);
        chk("rst_out_index", 32'(out_index4), 0);
        chk("rst_out_last", 32'(out_last4), 0);
        chk("rst_in_ready4", 32'(in_ready4), 0);
        chk("rst_in_ready16", 32'(in_ready16), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready4), 1);
        @(negedge clk);

        // table vectors with exact latency
        out_ready4 = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int j = 0; j < 4; j++) send4(tbl[v].din[j]);
            #1;
            chk("lat_not_yet", 32'(out_valid4), 0);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk); #1;
                chk("tbl_valid", 32'(out_valid4), 1);
                chk("tbl_data", 32'(out_data4), 32'(tbl[v].dout[j]));
                chk("tbl_index", 32'(out_index4), 32'(j));
                chk("tbl_last", 32'(out_last4), 32'(j == 3));
            end
            @(negedge clk); #1;
            chk("tbl_idle", 32'(out_valid4), 0);
            @(negedge clk);
        end

        // both banks full under backpressure
        out_ready4 = 1'b0;
        for (int k = 0; k < 4; k++) send4(8'h10 + 8'(k));
        for (int k = 0; k < 4; k++) send4(8'h20 + 8'(k));
        #1;
        chk("bp_in_ready_low", 32'(in_ready4), 0);
        chk("bp_hold_bin0", 32'(out_data4), 32'h10);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_hold_bin0_later", 32'(out_data4), 32'h10);
        chk("bp_hold_index", 32'(out_index4), 0);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(negedge clk); #1;
        chk("bp_ir_after_bin1", 32'(in_ready4), 0);
        @(negedge clk); #1;
        chk("bp_ir_after_bin2", 32'(in_ready4), 0);
        @(negedge clk); #1;
        chk("bp_ir_after_bin3", 32'(in_ready4), 1);
        @(negedge clk);
        drain4();

        // three back-to-back frames, SAMPLES=8
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    in_valid8 = 1'b1;
                    in_data8  = 8'(brev(k % 8, 3));
                    #1;
                    chk("s8_in_ready", 32'(in_ready8), 1);
                    @(negedge clk);
                end
                in_valid8 = 1'b0;
            end
            begin
                int n = 0;
                #1;
                while (!out_valid8 && n < 100) begin
                    @(negedge clk); #1; n++;
                end
                for (int j = 0; j < 24; j++) begin
                    chk("s8_no_gap", 32'(out_valid8), 1);
                    chk("s8_data", 32'(out_data8), 32'(j % 8));
                    @(negedge clk); #1;
                end
            end
        join
        @(negedge clk);
        chk("s8_left", 32'(q8.size()), 0);

        // random handshakes, 20 frames of 16
        begin
            bit done = 0;
            fork
                begin
                    int sent = 0;
                    int cyc = 0;
                    while (sent < 320 && cyc < 5000) begin
                        in_valid16 = 1'($urandom_range(0, 1));
                        in_data16  = 8'($urandom);
                        #1;
                        if (in_valid16 && in_ready16) sent++;
                        @(negedge clk);
                        cyc++;
                    end
                    in_valid16 = 1'b0;
                    chk("r16_sent", 32'(sent), 320);
                    done = 1;
                end
                begin
                    while (!done) begin
                        out_ready16 = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    out_ready16 = 1'b1;
                end
            join
            begin
                int n = 0;
                #1;
                while (q16.size() != 0 && n < 200) begin
                    @(negedge clk); #1; n++;
                end
                chk("r16_left", 32'(q16.size()), 0);
                chk("r16_received", 32'(rcv16), 320);
            end
            @(negedge clk);
        end

        // mid-frame reset while an output is stalled
        out_ready4 = 1'b0;
        for (int k = 0; k < 4; k++) send4(8'h60 + 8'(k));
        send4(8'h70);
        send4(8'h71);
        #1;
        chk("mr_out_valid_before", 32'(out_valid4), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready_low", 32'(in_ready4), 0);
        @(negedge clk); #1;
        chk("mr_out_valid_dropped", 32'(out_valid4), 0);
        chk("mr_in_ready_still_low", 32'(in_ready4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready4 = 1'b1;
        send4(8'd10); send4(8'd30); send4(8'd20); send4(8'd40);
        begin
            int n = 0;
            #1;
            while (!out_valid4 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            chk("mr_first_out", 32'(out_data4), 32'd10);
        end
        @(negedge clk);
        drain4();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
Streaming bit-reversal reorder buffer for the FFT output side. It is the inverse of the input-side scramble stage. The FFT core emits each frame of SAMPLES bins in bit-reversed order. This block buffers each frame and re-emits it in natural bin order (0..SAMPLES-1) to the display/magnitude path. It uses a ping-pong pair of banks and valid/ready handshakes on both sides, so continuous frames flow at full rate.

Parameters:
SAMPLES, 4, frame length in bins; power of two, at least 2
WIDTH, 2, bits per sample
IDX_W, $clog2(SAMPLES), index width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample
in_data  input  WIDTH  sample; k-th accepted sample of a frame is bin bitrev(k)
out_valid  output  1  out_data/out_index/out_last valid
out_ready  input  1  downstream accepts
out_data  output  WIDTH  sample in natural order
out_index  output  IDX_W  natural bin index of out_data
out_last  output  1  high with bin SAMPLES-1

Behaviour:
- Storage: two banks of SAMPLES x WIDTH, plus full[1:0]. Write bank pointer wb and read bank pointer rb. Write counter wc and read counter rc, each IDX_W bits. Bank contents are not reset.
- Reset (rst_n low at clk edge):
  - wb, rb, wc, rc cleared; full cleared.
  - out_valid=0, out_data=0, out_index=0, out_last=0.
  - in_ready is forced 0 while rst_n is low.
- in_ready = rst_n & ~full[wb]. This is combinational from registered state only; there is no path from in_valid.
- Write on (in_valid & in_ready):
  - bank[wb][bitrev(wc)] <= in_data; wc <= wc+1 (wraps).
  - If wc == SAMPLES-1: full[wb] <= 1 and wb toggles.
- Output load condition: full[rb] & (~out_valid | out_ready).
  - On load: out_data <= bank[rb][rc]; out_index <= rc; out_last <= (rc == SAMPLES-1); out_valid <= 1; rc <= rc+1.
  - If rc == SAMPLES-1: full[rb] <= 0 and rb toggles. The bank is freed when its last bin is loaded into the output register, not when that bin is accepted.
- If out_valid & out_ready and there is no load: out_valid <= 0.
- Output registers hold stable while out_valid & ~out_ready.
- Latency: last input handshake at edge E sets full. The first output is valid after edge E+1. Bin j of a frame is presented no earlier than E+1+j.
- Throughput: with out_ready held high, one input and one output per cycle sustained indefinitely.
- Both banks full: in_ready=0. It reasserts the cycle after the read bank is freed.
- Simultaneous set of full[wb] and clear of full[rb] in one cycle (different banks): both updates take effect.
- A read of the bank being written cannot occur, because the read side only addresses full banks.
- Mid-frame reset: the partial frame is discarded. out_valid drops at the reset edge regardless of out_ready. The first post-reset sample is bitrev index 0 of a new frame.
- No frame-marker input: framing is purely by count from reset.

Decomposition:
- Shared package fft_pkg: default SAMPLES/WIDTH constants for the FFT datapath.
- Sub-module bit_reverse_index #(IDX_W): combinational, idx_in -> idx_out with bit order reversed. Shared with the input scramble stage's index generation.
- Banks are inferred as register arrays inside fft_output_reorder.

Test Plan:
- SAMPLES=4, WIDTH=8, out_ready=1: in_data 10,30,20,40 on consecutive cycles -> out_data 10,20,30,40; out_index 0..3; out_last only on 40; first out_valid one edge after the 40 handshake.
- SAMPLES=8: in_data = bitrev(k) for k=0..7, three back-to-back frames with out_ready=1 -> out_data = 0..7 repeated three times; in_ready never drops; no gaps after the first frame.
- out_ready=0 throughout: feed 2 frames (8 samples, SAMPLES=4) -> in_ready=0 after the 8th handshake. Out holds bin 0 of frame 1 stable. Raise out_ready -> frames 1 then 2 emitted in natural order; in_ready returns 1 the cycle after bin 3 of frame 1 loads.
- Random out_ready (50%) and random in_valid over 20 frames, SAMPLES=16 -> scoreboard matches natural order exactly; no loss or duplication; outputs stable while stalled.
- Assert rst_n low after 2 samples of a frame, and also while out_valid=1 -> out_valid=0 and in_ready=0 during reset. Next frame 10,30,20,40 -> 10,20,30,40 with no stale data.
